uart_tx_sched: RTL
==================

# uart_tx_sched

Transmit scheduler that shares the single UART transmitter between two requesters: the echo path (bytes arriving on the UART receiver) and a host port (e.g. a VIO-driven or bus-side byte source). It buffers echo bytes in a small FIFO, arbitrates round-robin between the echo FIFO and the host, and drives the UART `transmit`/`tx_byte` strobe, tracking `is_transmitting` to sequence one byte at a time. It sits between the UART core and the bus-side logic, in the UART clock domain.

## Interface
- `FIFO_AW`, 2, echo FIFO address width; depth = 2^FIFO_AW (4)
- `TIMEOUT`, 16, max cycles `transmit` is held without `is_transmitting` rising; range 2..255
- `clk`  in  1  UART clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `received`  in  1  one-cycle pulse, echo byte valid on `rx_byte`
- `rx_byte`  in  8  received byte
- `host_req`  in  1  host has a byte to send; held until `host_ack`
- `host_byte`  in  8  host byte; stable while `host_req`=1
- `host_ack`  out  1  one-cycle pulse: host byte taken
- `transmit`  out  1  request to UART core to send `tx_byte`
- `tx_byte`  out  8  byte to UART core
- `is_transmitting`  in  1  UART core busy flag
- `grant_src`  out  1  source of current/last byte: 0 echo, 1 host
- `echo_ovf`  out  1  sticky: echo byte dropped (FIFO full)
- `tx_timeout`  out  1  one-cycle pulse: issue timed out, byte dropped

## Operation
- FSM states: IDLE, ISSUE, BUSY.
- IDLE: if echo FIFO non-empty or `host_req`=1, pick source, latch byte into `tx_byte`, pop FIFO (echo) or pulse `host_ack` (host), set `grant_src`, go ISSUE. Else stay.
- Arbitration: round-robin. Both pending -> source not granted last wins. One pending -> it wins. Last-granted register resets to host, so echo wins the first tie.
- ISSUE: `transmit`=1. On `is_transmitting`=1 -> `transmit`=0, go BUSY. If TIMEOUT cycles in ISSUE elapse without it -> `transmit`=0, pulse `tx_timeout`, go IDLE (byte discarded, not retried).
- BUSY: wait for `is_transmitting`=0, then go IDLE.
- Echo FIFO: push `rx_byte` on `received`. Full and no pop same cycle -> byte dropped, `echo_ovf` set (cleared only by reset). Push and pop same cycle while full -> push accepted, count unchanged. Pop from empty never occurs.
- Pointers are FIFO_AW bits, wrap naturally; count is FIFO_AW+1 bits.
- Reset (any state, incl. mid-ISSUE/BUSY): FSM to IDLE, FIFO emptied, all outputs 0 (`transmit`, `tx_byte`=8'h00, `host_ack`, `grant_src`, `echo_ovf`, `tx_timeout`), last-granted = host, timeout counter 0. An in-flight UART frame is not aborted; after reset release the scheduler waits in IDLE and only issues when a request exists (it does not check `is_transmitting` in IDLE; UART core ignores `transmit` while busy is not relied on — ISSUE simply waits for the rising/high flag).

## Timing
- All outputs registered.
- Request seen in IDLE at cycle N -> `transmit`=1 and `tx_byte` valid at N+1; `host_ack` high exactly at N+1 for one cycle.
- Host must deassert `host_req` or present a new byte at N+2; `host_req` sampled high at N+2 is a new request (cannot be granted before IDLE re-entry anyway).
- `is_transmitting`=1 sampled at cycle M in ISSUE -> `transmit`=0 at M+1.
- Timeout: `transmit` high for exactly TIMEOUT cycles, `tx_timeout` pulses in the cycle `transmit` falls.
- `is_transmitting`=0 sampled in BUSY -> IDLE next cycle; minimum one IDLE cycle between bytes.
- `received` to FIFO visible (non-empty seen in IDLE): 1 cycle.

## Configuration
- `UART_TX_SCHED_ECHO_EN` defined: echo FIFO and echo arbitration compiled in, as above.
- Not defined: FIFO and round-robin logic removed; `received`/`rx_byte` ignored; host is the only source; `grant_src` = 1 after first grant (0 from reset); `echo_ovf` tied 0.

## Test plan
- Single echo: `received` with 8'h41, UART responds `is_transmitting` 2 cycles after `transmit` -> `tx_byte`=8'h41, `grant_src`=0, `transmit` high 3 cycles, back to IDLE after busy drops.
- Tie: FIFO holds 8'h10, `host_req` with 8'hA5 same cycle -> order 8'h10, 8'hA5; with both still pending (8'h11, 8'hA6) -> 8'h11, 8'hA6 alternate.
- Overflow: 6 `received` pulses (8'h01..8'h06) while UART busy -> 8'h01 issued, 8'h02..8'h05 buffered, 8'h06 dropped, `echo_ovf`=1; output sequence 01,02,03,04,05.
- Timeout: host sends 8'h7E, `is_transmitting` held 0 -> `transmit` high 16 cycles, `tx_timeout` one pulse, `host_ack` one pulse, FSM IDLE.
- Reset mid-BUSY with 3 bytes queued: assert `rst`=0 -> all outputs 0 immediately, FIFO empty; after release no `transmit` until new request.
- Macro undefined: `received` pulses with 8'h55 -> no `transmit`; host 8'h33 -> sent normally.

Source files
------------

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: shares one UART transmitter between an echo byte FIFO and a host byte port.
// Optional echo path (FIFO + round-robin) is compiled in with `define UART_TX_SCHED_ECHO_EN.
module uart_tx_sched #(
  parameter int FIFO_AW = 2,
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       received,
  input  logic [7:0] rx_byte,
  input  logic       host_req,
  input  logic [7:0] host_byte,
  output logic       host_ack,
  output logic       transmit,
  output logic [7:0] tx_byte,
  input  logic       is_transmitting,
  output logic       grant_src,
  output logic       echo_ovf,
  output logic       tx_timeout
);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic       transmit_nxt;
  logic       host_ack_nxt;
  logic       grant_src_nxt;
  logic       tx_timeout_nxt;
  logic [7:0] tx_byte_nxt;
  logic [7:0] tmo_cnt, tmo_cnt_nxt;
  logic       pick_echo;
  logic [7:0] echo_head;
  logic       echo_pop;

`ifdef UART_TX_SCHED_ECHO_EN
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};

  logic [7:0]         fifo_mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   fifo_cnt;
  logic               fifo_full;
  logic               push_ok;
  logic               last_host, last_host_nxt;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign fifo_full = (fifo_cnt == FULL_CNT);
  assign push_ok   = received && (!fifo_full || echo_pop);
  assign echo_head = fifo_mem[rd_ptr];
  assign pick_echo = (fifo_cnt != '0) && (!host_req || last_host);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
      echo_ovf  <= 1'b0;
      last_host <= 1'b1;
    end else begin
      last_host <= last_host_nxt;
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (echo_pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !echo_pop)
        fifo_cnt <= fifo_cnt + 1'b1;
      else if (!push_ok && echo_pop)
        fifo_cnt <= fifo_cnt - 1'b1;
      if (received && !push_ok)
        echo_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      fifo_mem[wr_ptr] <= rx_byte;
  end
`else
  logic [FIFO_AW:0] unused_fifo_cnt;
  logic             unused_echo;

  assign unused_fifo_cnt = '0;
  assign unused_echo     = ^{received, rx_byte, echo_pop, unused_fifo_cnt};
  assign pick_echo       = 1'b0;
  assign echo_head       = 8'h00;
  assign echo_ovf        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      transmit   <= 1'b0;
      tx_byte    <= 8'h00;
      host_ack   <= 1'b0;
      grant_src  <= 1'b0;
      tx_timeout <= 1'b0;
      tmo_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      transmit   <= transmit_nxt;
      tx_byte    <= tx_byte_nxt;
      host_ack   <= host_ack_nxt;
      grant_src  <= grant_src_nxt;
      tx_timeout <= tx_timeout_nxt;
      tmo_cnt    <= tmo_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    transmit_nxt   = transmit;
    tx_byte_nxt    = tx_byte;
    grant_src_nxt  = grant_src;
    host_ack_nxt   = 1'b0;
    tx_timeout_nxt = 1'b0;
    tmo_cnt_nxt    = tmo_cnt;
    echo_pop       = 1'b0;
`ifdef UART_TX_SCHED_ECHO_EN
    last_host_nxt  = last_host;
`endif
    case (state)
      IDLE: begin
        if (pick_echo) begin
          tx_byte_nxt   = echo_head;
          echo_pop      = 1'b1;
          grant_src_nxt = 1'b0;
          transmit_nxt  = 1'b1;
          tmo_cnt_nxt   = '0;
          state_nxt     = ISSUE;
`ifdef UART_TX_SCHED_ECHO_EN
          last_host_nxt = 1'b0;
`endif
        end else if (host_req) begin
          tx_byte_nxt   = host_byte;
          host_ack_nxt  = 1'b1;
          grant_src_nxt = 1'b1;
          transmit_nxt  = 1'b1;
          tmo_cnt_nxt   = '0;
          state_nxt     = ISSUE;
`ifdef UART_TX_SCHED_ECHO_EN
          last_host_nxt = 1'b1;
`endif
        end
      end
      // A busy flag seen in the last allowed cycle still counts as accepted.
      ISSUE: begin
        if (is_transmitting) begin
          transmit_nxt = 1'b0;
          state_nxt    = BUSY;
        end else if (tmo_cnt == TIMEOUT_LAST) begin
          transmit_nxt   = 1'b0;
          tx_timeout_nxt = 1'b1;
          state_nxt      = IDLE;
        end else begin
          tmo_cnt_nxt = tmo_cnt + 8'd1;
        end
      end
      BUSY: begin
        if (!is_transmitting)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
